// File: rtl/zacore_pipeline_ctrl_pkg.sv
// Shared types for the Zacore pipeline controller: FSM states, per-stage
// hold/clear bundle, fetch redirect record and the halfword-aligned PC type.
package zacore_pipeline_ctrl_pkg;

    localparam int PC_W = 31;

    // Fetch addresses are halfword aligned, so bit 0 is never stored.
    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic [3:0] stall;
        logic [3:0] flush;
    } pipe_ctrl_t;

    typedef struct packed {
        logic valid;
        pc_t  pc;
    } redirect_t;

    function automatic pc_t byte_addr_to_pc(input logic [31:0] addr);
        return addr[31:1];
    endfunction

endpackage

// File: rtl/zacore_pipeline_ctrl_if.sv
// Hazard/sequencing bundle between the pipeline stages and the controller.
// master = pipeline side (drives status), slave = controller side.
interface zacore_pipeline_ctrl_if #(
    parameter int STALL_CNT_W = 32
);
    import zacore_pipeline_ctrl_pkg::*;

    logic                   i_fetch_busy;
    logic                   i_decode_load_use;
    logic                   i_exec_redirect_valid;
    pc_t                    i_exec_redirect_pc;
    logic                   i_mem_busy;
    logic                   i_halt_req;
    logic [3:0]             i_stage_valid;
    logic [3:0]             o_stall;
    logic [3:0]             o_flush;
    logic                   o_redirect_valid;
    pc_t                    o_redirect_pc;
    logic                   o_halted;
    logic [STALL_CNT_W-1:0] o_stall_count;

    modport master (
        output i_fetch_busy, i_decode_load_use, i_exec_redirect_valid,
               i_exec_redirect_pc, i_mem_busy, i_halt_req, i_stage_valid,
        input  o_stall, o_flush, o_redirect_valid, o_redirect_pc,
               o_halted, o_stall_count
    );

    modport slave (
        input  i_fetch_busy, i_decode_load_use, i_exec_redirect_valid,
               i_exec_redirect_pc, i_mem_busy, i_halt_req, i_stage_valid,
        output o_stall, o_flush, o_redirect_valid, o_redirect_pc,
               o_halted, o_stall_count
    );

endinterface

// File: rtl/zacore_pipeline_ctrl_sat_counter.sv
// Saturating up-counter: increments on i_inc, sticks at all-ones, never wraps.
module zacore_sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/zacore_pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage Zacore pipeline: per-register
// stall/flush, fetch redirect (boot vector, execute branches), halt/drain, stall count.
module zacore_pipeline_ctrl
    import zacore_pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC          = 32'h0000_0000,
    parameter int          BOOT_FLUSH_CYCLES = 2,
    parameter int          STALL_CNT_W       = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    zacore_pipeline_ctrl_if.slave  bus
);

    localparam int BCNT_W = (BOOT_FLUSH_CYCLES > 1) ? $clog2(BOOT_FLUSH_CYCLES) : 1;
    localparam logic [BCNT_W-1:0] BOOT_LAST = BCNT_W'(BOOT_FLUSH_CYCLES - 1);
    localparam pc_t RESET_PC_T = RESET_PC[31:1];

    ctrl_state_t       state_q, state_d;
    logic [BCNT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic              pending_q, pending_d;
    pc_t               pending_pc_q, pending_pc_d;

    pipe_ctrl_t ctrl;
    redirect_t  redir;
    logic       halted;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= BOOT;
            boot_cnt_q   <= '0;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
        end else begin
            state_q      <= state_d;
            boot_cnt_q   <= boot_cnt_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    always_comb begin
        ctrl         = '0;
        redir        = '0;
        halted       = 1'b0;
        state_d      = state_q;
        boot_cnt_d   = boot_cnt_q;
        pending_d    = pending_q;
        pending_pc_d = pending_pc_q;

        // Outputs track reset combinationally so the pipeline is cleared at once.
        if (i_rst) begin
            ctrl.flush = 4'hF;
        end else begin
            case (state_q)
                BOOT: begin
                    ctrl.flush = 4'hF;
                    if (boot_cnt_q == BOOT_LAST) begin
                        redir.valid = 1'b1;
                        redir.pc    = RESET_PC_T;
                        state_d     = RUN;
                    end else begin
                        boot_cnt_d = boot_cnt_q + BCNT_W'(1);
                    end
                end

                RUN, DRAIN: begin
                    if (bus.i_mem_busy) begin
                        ctrl.stall    = 4'b0111;
                        ctrl.flush[3] = 1'b1;
                        // Only the first redirect seen under a D-mem wait is kept.
                        if (bus.i_exec_redirect_valid && !pending_q) begin
                            pending_d    = 1'b1;
                            pending_pc_d = bus.i_exec_redirect_pc;
                        end
                    end else if (pending_q || bus.i_exec_redirect_valid) begin
                        redir.valid      = 1'b1;
                        redir.pc         = pending_q ? pending_pc_q : bus.i_exec_redirect_pc;
                        ctrl.flush[1:0]  = 2'b11;
                        pending_d        = 1'b0;
                    end else if (bus.i_decode_load_use) begin
                        ctrl.stall[0] = 1'b1;
                        ctrl.flush[1] = 1'b1;
                    end else if (bus.i_fetch_busy) begin
                        ctrl.flush[0] = 1'b1;
                    end

                    if (state_q == RUN) begin
                        if (bus.i_halt_req) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        ctrl.flush[0] = 1'b1;
                        if (!bus.i_halt_req) begin
                            state_d = RUN;
                        end else if ((bus.i_stage_valid == 4'b0000) && !pending_q) begin
                            state_d = HALTED;
                        end
                    end
                end

                HALTED: begin
                    halted        = 1'b1;
                    ctrl.flush[0] = 1'b1;
                    if (!bus.i_halt_req) begin
                        state_d = RUN;
                    end
                end

                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    assign bus.o_stall          = ctrl.stall;
    assign bus.o_flush          = ctrl.flush;
    assign bus.o_redirect_valid = redir.valid;
    assign bus.o_redirect_pc    = redir.pc;
    assign bus.o_halted         = halted;

    zacore_sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (ctrl.stall[0]),
        .o_count (bus.o_stall_count)
    );

endmodule

// File: tb/tb_zacore_pipeline_ctrl.sv
// Directed bench for zacore_pipeline_ctrl: boot, hazards, pending redirect,
// halt/drain, stall counter saturation and asynchronous reset.
module tb_zacore_pipeline_ctrl;
    import zacore_pipeline_ctrl_pkg::*;

    localparam int CW = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    zacore_pipeline_ctrl_if #(.STALL_CNT_W(CW)) bus ();

    zacore_pipeline_ctrl #(
        .RESET_PC          (32'h0000_0000),
        .BOOT_FLUSH_CYCLES (2),
        .STALL_CNT_W       (CW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] st, input logic [3:0] fl,
                           input logic rv, input pc_t pc, input logic h);
        check({tag, ".stall"}, 32'(bus.o_stall), 32'(st));
        check({tag, ".flush"}, 32'(bus.o_flush), 32'(fl));
        check({tag, ".rv"}, 32'(bus.o_redirect_valid), 32'(rv));
        if (rv) check({tag, ".rpc"}, 32'(bus.o_redirect_pc), 32'(pc));
        check({tag, ".halted"}, 32'(bus.o_halted), 32'(h));
    endtask

    task automatic idle();
        bus.i_fetch_busy          = 1'b0;
        bus.i_decode_load_use     = 1'b0;
        bus.i_exec_redirect_valid = 1'b0;
        bus.i_exec_redirect_pc    = '0;
        bus.i_mem_busy            = 1'b0;
        bus.i_halt_req            = 1'b0;
        bus.i_stage_valid         = 4'b0000;
    endtask

    // Advance to the next negedge, idle all inputs; caller then sets the cycle's inputs.
    task automatic next_cyc();
        @(negedge clk);
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk      = 1'b0;
        rst      = 1'b1;
        idle();

        // T1: reset and boot
        #1;
        chk_out("rst", 4'h0, 4'hF, 1'b0, '0, 1'b0);
        check("rst.count", 32'(bus.o_stall_count), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1; chk_out("boot0", 4'h0, 4'hF, 1'b0, '0, 1'b0);
        next_cyc(); #1; chk_out("boot1", 4'h0, 4'hF, 1'b1, pc_t'(0), 1'b0);
        next_cyc(); #1; chk_out("run0", 4'h0, 4'h0, 1'b0, '0, 1'b0);

        // T2: load-use bubble
        next_cyc(); bus.i_decode_load_use = 1'b1;
        #1; chk_out("lu", 4'b0001, 4'b0010, 1'b0, '0, 1'b0);
        check("lu.count0", 32'(bus.o_stall_count), 32'd0);
        next_cyc(); #1; chk_out("lu.after", 4'h0, 4'h0, 1'b0, '0, 1'b0);
        check("lu.count1", 32'(bus.o_stall_count), 32'd1);

        // T3: redirect captured under mem_busy, later repeat ignored
        next_cyc(); bus.i_mem_busy = 1'b1; bus.i_exec_redirect_valid = 1'b1;
        bus.i_exec_redirect_pc = pc_t'('h100);
        #1; chk_out("mb1", 4'b0111, 4'b1000, 1'b0, '0, 1'b0);
        next_cyc(); bus.i_mem_busy = 1'b1; bus.i_exec_redirect_valid = 1'b1;
        bus.i_exec_redirect_pc = pc_t'('h200);
        #1; chk_out("mb2", 4'b0111, 4'b1000, 1'b0, '0, 1'b0);
        next_cyc(); bus.i_mem_busy = 1'b1;
        #1; chk_out("mb3", 4'b0111, 4'b1000, 1'b0, '0, 1'b0);
        next_cyc(); bus.i_decode_load_use = 1'b1;
        #1; chk_out("mb.redir", 4'h0, 4'b0011, 1'b1, pc_t'('h100), 1'b0);
        check("mb.count", 32'(bus.o_stall_count), 32'd4);
        next_cyc(); #1; chk_out("mb.clear", 4'h0, 4'h0, 1'b0, '0, 1'b0);

        // T4: redirect beats load-use and fetch_busy
        next_cyc(); bus.i_exec_redirect_valid = 1'b1; bus.i_exec_redirect_pc = pc_t'('h2A4);
        bus.i_decode_load_use = 1'b1; bus.i_fetch_busy = 1'b1;
        #1; chk_out("br.lu", 4'h0, 4'b0011, 1'b1, pc_t'('h2A4), 1'b0);
        next_cyc(); bus.i_fetch_busy = 1'b1;
        #1; chk_out("fbusy", 4'h0, 4'b0001, 1'b0, '0, 1'b0);

        // T5: halt/drain
        next_cyc(); bus.i_halt_req = 1'b1; bus.i_stage_valid = 4'b1111;
        #1; chk_out("halt.run", 4'h0, 4'h0, 1'b0, '0, 1'b0);
        next_cyc(); bus.i_halt_req = 1'b1; bus.i_stage_valid = 4'b0111;
        #1; chk_out("drain1", 4'h0, 4'b0001, 1'b0, '0, 1'b0);
        next_cyc(); bus.i_halt_req = 1'b1; bus.i_stage_valid = 4'b0011; bus.i_decode_load_use = 1'b1;
        #1; chk_out("drain2.lu", 4'b0001, 4'b0011, 1'b0, '0, 1'b0);
        next_cyc(); bus.i_halt_req = 1'b1; bus.i_stage_valid = 4'b0001;
        #1; chk_out("drain3", 4'h0, 4'b0001, 1'b0, '0, 1'b0);
        check("drain.count", 32'(bus.o_stall_count), 32'd5);
        next_cyc(); bus.i_halt_req = 1'b1;
        #1; chk_out("drain4", 4'h0, 4'b0001, 1'b0, '0, 1'b0);
        next_cyc(); bus.i_halt_req = 1'b1; bus.i_decode_load_use = 1'b1;
        #1; chk_out("halted", 4'h0, 4'b0001, 1'b0, '0, 1'b1);
        next_cyc();
        #1; chk_out("halted.rel", 4'h0, 4'b0001, 1'b0, '0, 1'b1);
        next_cyc(); #1; chk_out("resume", 4'h0, 4'h0, 1'b0, '0, 1'b0);
        check("resume.count", 32'(bus.o_stall_count), 32'd5);

        // DRAIN aborted by dropping halt_req
        next_cyc(); bus.i_halt_req = 1'b1; bus.i_stage_valid = 4'b1111;
        #1; chk_out("abort.run", 4'h0, 4'h0, 1'b0, '0, 1'b0);
        next_cyc(); bus.i_stage_valid = 4'b1111;
        #1; chk_out("abort.drain", 4'h0, 4'b0001, 1'b0, '0, 1'b0);
        next_cyc(); #1; chk_out("abort.run2", 4'h0, 4'h0, 1'b0, '0, 1'b0);

        // T6: saturation, then async reset discards a pending redirect
        for (int i = 0; i < 20; i++) begin
            next_cyc(); bus.i_decode_load_use = 1'b1;
            #1;
            if (i == 5 || i == 9 || i == 10 || i == 19)
                check($sformatf("sat.count%0d", i), 32'(bus.o_stall_count),
                      32'((5 + i > 15) ? 15 : 5 + i));
        end
        next_cyc(); #1;
        check("sat.final", 32'(bus.o_stall_count), 32'd15);
        next_cyc(); bus.i_mem_busy = 1'b1; bus.i_exec_redirect_valid = 1'b1;
        bus.i_exec_redirect_pc = pc_t'('h3C0);
        #3; rst = 1'b1;
        #1; chk_out("arst", 4'h0, 4'hF, 1'b0, '0, 1'b0);
        check("arst.count", 32'(bus.o_stall_count), 32'd0);
        next_cyc(); rst = 1'b0;
        #1; chk_out("reboot0", 4'h0, 4'hF, 1'b0, '0, 1'b0);
        next_cyc(); #1; chk_out("reboot1", 4'h0, 4'hF, 1'b1, pc_t'(0), 1'b0);
        next_cyc(); #1; chk_out("reboot.run", 4'h0, 4'h0, 1'b0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
